// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM encoding and width helper for the UART TX arbiter
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_DONE = 2'd1,
    ST_GAP       = 2'd2
  } arb_state_e;

  // Smallest r with 2**r >= value; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester handshake and UART TX launch/done bundle
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          tx_start;
  logic [DATA_WIDTH-1:0]         tx_data;
  logic                          tx_done;

  modport master (
    output req_valid, output req_data, input req_ready,
    input tx_start, input tx_data, output tx_done
  );

  modport slave (
    input req_valid, input req_data, output req_ready,
    output tx_start, output tx_data, input tx_done
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// rtl/uart_tx_arbiter_rr_picker.sv - combinational round-robin priority encoder
module rr_picker
  import uart_pkg::*;
#(
  parameter int  NUM_REQ = 4,
  localparam int IDX_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic               any_o,
  output logic [IDX_W-1:0]   winner_o
);

  logic [IDX_W-1:0] idx;

  // Scan from the farthest offset down so the requester closest to rr_ptr wins.
  always_comb begin
    any_o    = 1'b0;
    winner_o = '0;
    idx      = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = IDX_W'((int'(rr_ptr_i) + i) % NUM_REQ);
      if (req_valid_i[idx]) begin
        any_o    = 1'b1;
        winner_o = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one UART transmitter with gap and watchdog
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int  NUM_REQ        = 4,
  parameter int  DATA_WIDTH     = 8,
  parameter int  GAP_CYCLES     = 0,
  parameter int  TIMEOUT_CYCLES = 200000,
  localparam int IDX_W          = clog2(NUM_REQ)
) (
  input  logic              clk,
  input  logic              srst,
  uart_tx_arbiter_if.slave  bus,
  output logic              busy,
  output logic [IDX_W-1:0]  grant_id,
  output logic              tx_timeout
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LOAD     = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam arb_state_e       AFTER_FRAME  = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

  arb_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]      grant_q;
  logic [DATA_WIDTH-1:0] tx_data_q;
  logic [NUM_REQ-1:0]    req_ready_q;
  logic                  tx_start_q;
  logic                  tx_done_q;

  logic                  pick_any;
  logic [IDX_W-1:0]      pick_winner;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  done_edge;
  logic                  cnt_zero;
  logic                  grant;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_valid_i (bus.req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .any_o       (pick_any),
    .winner_o    (pick_winner)
  );

  assign done_edge = bus.tx_done & ~tx_done_q;
  assign cnt_zero  = (cnt_q == '0);
  assign grant     = (state_q == ST_IDLE) && pick_any;

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_winner == IDX_W'(i)) win_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (srst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (pick_any) state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (done_edge || cnt_zero) state_d = AFTER_FRAME;
      ST_GAP:       if (cnt_zero) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // A completion edge wins over a simultaneous watchdog expiry.
  always_comb begin
    busy       = (state_q != ST_IDLE);
    tx_timeout = (state_q == ST_WAIT_DONE) && cnt_zero && !done_edge;
  end

  // One down-counter serves the watchdog in WAIT_DONE and the gap in GAP.
  always_comb begin
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_IDLE:      cnt_d = TIMEOUT_LOAD;
      ST_WAIT_DONE: cnt_d = (done_edge || cnt_zero) ? GAP_LOAD : cnt_q - 1'b1;
      ST_GAP:       if (!cnt_zero) cnt_d = cnt_q - 1'b1;
      default:      cnt_d = cnt_q;
    endcase
    if (grant) rr_ptr_d = (pick_winner == IDX_W'(NUM_REQ - 1)) ? '0 : pick_winner + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_q       <= '0;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      tx_data_q   <= '0;
      req_ready_q <= '0;
      tx_start_q  <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      tx_done_q   <= bus.tx_done;
      tx_start_q  <= grant;
      req_ready_q <= grant ? (NUM_REQ'(1) << pick_winner) : '0;
      if (grant) begin
        grant_q   <= pick_winner;
        tx_data_q <= win_data;
      end
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.tx_start  = tx_start_q;
  assign bus.tx_data   = tx_data_q;
  assign grant_id      = grant_q;

endmodule
